// File: rtl/conv2d_axi_lite_master.sv
//----------------------------------------------------------------------------
// conv2d_axi_lite_master : AXI4-Lite initiator that loads, starts, polls and
// reads back one conv2d_axi_lite accelerator.          Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module conv2d_axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int POLL_MAX           = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [71:0]                     pix_flat,
  input  logic [71:0]                     wgt_flat,
  output logic                            busy,
  output logic [15:0]                     result,
  output logic                            result_valid,
  output logic                            error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int                            PW        = $clog2(POLL_MAX + 1);
  localparam logic [4:0]                    LAST_IDX  = 5'd18;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_RES  = C_M_AXI_ADDR_WIDTH'(7'h4C);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;

  state_t                          state_q;
  logic [17:0][7:0]                opnd_q;
  logic [4:0]                      idx_q;
  logic [PW-1:0]                   poll_q;
  logic                            sent_q, aw_done_q, w_done_q;
  logic                            busy_q, result_valid_q, error_q;
  logic [15:0]                     result_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic [7:0]                      op_byte;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data_d;
  logic                            aw_hs, w_hs, aw_fin, w_fin;
  logic                            unused_rdata;

  // Pixels and weights sit in one 18-byte array, so both land at 0x04 + 4*idx.
  always_comb begin
    op_byte = 8'h00;
    if (idx_q < LAST_IDX) op_byte = opnd_q[idx_q];
    wr_addr_d = '0;
    wr_data_d = C_M_AXI_DATA_WIDTH'(1);
    if (idx_q != LAST_IDX) begin
      wr_addr_d = C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00}) + C_M_AXI_ADDR_WIDTH'(4);
      wr_data_d = {{(C_M_AXI_DATA_WIDTH-8){op_byte[7]}}, op_byte};
    end
  end

  assign aw_hs  = awvalid_q & M_AXI_AWREADY;
  assign w_hs   = wvalid_q & M_AXI_WREADY;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;
  assign unused_rdata = ^M_AXI_RDATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      opnd_q         <= '0;
      idx_q          <= '0;
      poll_q         <= '0;
      sent_q         <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      result_q       <= '0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      wdata_q        <= '0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd_q  <= {wgt_flat, pix_flat};
            idx_q   <= '0;
            poll_q  <= '0;
            sent_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!sent_q) begin
            sent_q    <= 1'b1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= wr_addr_d;
            wdata_q   <= wr_data_d;
          end else begin
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if (aw_fin && w_fin) begin
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              sent_q    <= 1'b0;
              bready_q  <= 1'b1;
              state_q   <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= ERR;
            end else if (idx_q == LAST_IDX) begin
              araddr_q <= ADDR_CTRL;
              state_q  <= RD_REQ;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!sent_q) begin
            sent_q    <= 1'b1;
            arvalid_q <= 1'b1;
          end else if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            sent_q    <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            if (M_AXI_RRESP != 2'b00) begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= ERR;
            end else if (araddr_q == ADDR_CTRL) begin
              if (M_AXI_RDATA[1]) begin
                araddr_q <= ADDR_RES;
                state_q  <= RD_REQ;
              end else if (poll_q + PW'(1) == PW'(POLL_MAX)) begin
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                state_q <= ERR;
              end else begin
                poll_q  <= poll_q + PW'(1);
                state_q <= RD_REQ;
              end
            end else begin
              result_q       <= M_AXI_RDATA[15:0];
              result_valid_q <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign result        = result_q;
  assign result_valid  = result_valid_q;
  assign error         = error_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_conv2d_axi_lite_master.sv
//----------------------------------------------------------------------------
// tb_conv2d_axi_lite_master : directed bench with an accelerator-like slave.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_conv2d_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [71:0] pix_flat = '0;
  logic [71:0] wgt_flat = '0;
  logic        busy, result_valid, error;
  logic [15:0] result;
  logic [6:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [31:0] M_AXI_WDATA;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;

  int n_assert = 0;
  int n_fail   = 0;

  // slave configuration, driven by the stimulus block
  int         aw_dly = 0;
  int         w_dly  = 0;
  logic [6:0] err_addr = 7'h7F;
  logic       never_done = 1'b0;
  logic       log_clr = 1'b0;

  // slave state
  logic        have_aw, have_w, bvalid, rvalid, done_flag;
  logic [1:0]  bresp;
  logic [6:0]  aw_addr_q;
  logic [31:0] w_data_q, rdata, res_val;
  int          aw_cnt, w_cnt, wcount, rcount, viol;
  logic [31:0] regs [0:31];
  logic [6:0]  wlog_addr [0:63];
  logic [31:0] wlog_data [0:63];
  logic [6:0]  rlog_addr [0:15];
  logic        pv_awp, pv_wp, pv_awhs, pv_whs, pv_arhs;
  logic [6:0]  pv_awaddr;
  logic [31:0] pv_wdata;

  logic        aw_rdy, w_rdy, ar_rdy, wr_fire;
  logic [6:0]  cur_aw;
  logic [31:0] cur_w;

  assign aw_rdy  = M_AXI_AWVALID && !have_aw && (aw_cnt >= aw_dly);
  assign w_rdy   = M_AXI_WVALID && !have_w && (w_cnt >= w_dly);
  assign ar_rdy  = M_AXI_ARVALID;
  assign cur_aw  = aw_rdy ? M_AXI_AWADDR : aw_addr_q;
  assign cur_w   = w_rdy ? M_AXI_WDATA : w_data_q;
  assign wr_fire = (aw_rdy || have_aw) && (w_rdy || have_w);

  conv2d_axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(7),
    .C_M_AXI_DATA_WIDTH(32),
    .POLL_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_flat(pix_flat), .wgt_flat(wgt_flat),
    .busy(busy), .result(result), .result_valid(result_valid), .error(error),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(aw_rdy),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(w_rdy),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(ar_rdy),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(2'b00), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] conv_sum();
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'($signed(regs[1+k])) * int'($signed(regs[10+k]));
    return 32'(s);
  endfunction

  // Accelerator-like slave with programmable ready delays and protocol monitor
  always @(posedge clk) begin
    if (rst || log_clr) begin
      have_aw <= 1'b0; have_w <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0;
      wcount <= 0; rcount <= 0; viol <= 0; done_flag <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0;
      pv_awp <= 1'b0; pv_wp <= 1'b0; pv_awhs <= 1'b0; pv_whs <= 1'b0; pv_arhs <= 1'b0;
      pv_awaddr <= '0; pv_wdata <= '0;
    end else begin
      viol <= viol
            + int'(pv_awp && (!M_AXI_AWVALID || M_AXI_AWADDR != pv_awaddr))
            + int'(pv_wp && (!M_AXI_WVALID || M_AXI_WDATA != pv_wdata))
            + int'(pv_awhs && M_AXI_AWVALID)
            + int'(pv_whs && M_AXI_WVALID)
            + int'(pv_arhs && M_AXI_ARVALID)
            + int'(M_AXI_ARVALID && (M_AXI_AWVALID || M_AXI_WVALID));
      pv_awp    <= M_AXI_AWVALID && !aw_rdy;
      pv_wp     <= M_AXI_WVALID && !w_rdy;
      pv_awhs   <= aw_rdy;
      pv_whs    <= w_rdy;
      pv_arhs   <= ar_rdy;
      pv_awaddr <= M_AXI_AWADDR;
      pv_wdata  <= M_AXI_WDATA;
      aw_cnt <= aw_rdy ? 0 : (M_AXI_AWVALID ? aw_cnt + 1 : 0);
      w_cnt  <= w_rdy  ? 0 : (M_AXI_WVALID  ? w_cnt + 1  : 0);
      if (bvalid && M_AXI_BREADY) bvalid <= 1'b0;
      if (wr_fire) begin
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (cur_aw == err_addr) ? 2'b10 : 2'b00;
        regs[cur_aw[6:2]] <= cur_w;
        if (wcount < 64) begin
          wlog_addr[wcount] <= cur_aw;
          wlog_data[wcount] <= cur_w;
        end
        wcount <= wcount + 1;
        if (cur_aw == 7'h00 && cur_w[0]) begin
          done_flag <= !never_done;
          res_val   <= conv_sum();
        end
      end else begin
        if (aw_rdy) begin have_aw <= 1'b1; aw_addr_q <= M_AXI_AWADDR; end
        if (w_rdy)  begin have_w  <= 1'b1; w_data_q  <= M_AXI_WDATA;  end
      end
      if (rvalid && M_AXI_RREADY) rvalid <= 1'b0;
      if (ar_rdy) begin
        rvalid <= 1'b1;
        if (rcount < 16) rlog_addr[rcount] <= M_AXI_ARADDR;
        rcount <= rcount + 1;
        if (M_AXI_ARADDR == 7'h00)      rdata <= {30'b0, done_flag, 1'b0};
        else if (M_AXI_ARADDR == 7'h4C) rdata <= {16'hA5A5, res_val[15:0]};
        else                            rdata <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_bfm();
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [71:0] p, input logic [71:0] w);
    pix_flat = p;
    wgt_flat = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max, output int cyc, output logic rv, output logic er);
    cyc = 0; rv = 1'b0; er = 1'b0;
    while (!rv && !er && cyc < max) begin
      @(negedge clk);
      cyc++;
      rv = result_valid;
      er = error;
    end
  endtask

  task automatic check_seq(input string tag, input int n, input logic [71:0] p, input logic [71:0] w);
    logic [7:0]  b;
    logic [6:0]  ea;
    logic [31:0] ed;
    chk({tag, "_wcount"}, wcount, n);
    for (int i = 0; i < n && i < 19; i++) begin
      if (i < 9) begin
        b = p[8*i +: 8]; ea = 7'(7'h04 + 4*i); ed = {{24{b[7]}}, b};
      end else if (i < 18) begin
        b = w[8*(i-9) +: 8]; ea = 7'(7'h28 + 4*(i-9)); ed = {{24{b[7]}}, b};
      end else begin
        ea = 7'h00; ed = 32'h1;
      end
      chk($sformatf("%s_addr%0d", tag, i), 32'(wlog_addr[i]), 32'(ea));
      chk($sformatf("%s_data%0d", tag, i), wlog_data[i], ed);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic rv, er;
    logic [71:0] p_ones, p_seq, p_ff, p_80, p_7f, p_2, p_3, p_4;
    p_ones = {9{8'h01}};
    p_seq  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    p_ff   = {9{8'hFF}};
    p_80   = {9{8'h80}};
    p_7f   = {9{8'h7F}};
    p_2    = {9{8'h02}};
    p_3    = {9{8'h03}};
    p_4    = {9{8'h04}};

    // reset state
    @(negedge clk);
    chk("rst_awvalid", 32'(M_AXI_AWVALID), 0);
    chk("rst_wvalid",  32'(M_AXI_WVALID), 0);
    chk("rst_bready",  32'(M_AXI_BREADY), 0);
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("rst_rready",  32'(M_AXI_RREADY), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_rvalid",  32'(result_valid), 0);
    chk("rst_error",   32'(error), 0);
    chk("rst_result",  32'(result), 0);
    rst = 1'b0;
    @(negedge clk);
    clear_bfm();

    // 1: all ones -> 9, 64-cycle minimum latency (DONE is cycle 63 after accept)
    pulse_start(p_ones, p_ones);
    chk("t1_busy_hi", 32'(busy), 1);
    wait_end(400, cyc, rv, er);
    chk("t1_rv", 32'(rv), 1);
    chk("t1_latency", cyc, 63);
    chk("t1_result", 32'(result), 32'h0009);
    @(negedge clk);
    chk("t1_rv_pulse", 32'(result_valid), 0);
    chk("t1_busy_lo", 32'(busy), 0);
    check_seq("t1", 19, p_ones, p_ones);
    chk("t1_rcount", rcount, 2);
    chk("t1_rd0", 32'(rlog_addr[0]), 32'h00);
    chk("t1_rd1", 32'(rlog_addr[1]), 32'h4C);
    chk("t1_viol", viol, 0);

    // 2: pixels 1..9, weights -1 -> -45
    clear_bfm();
    pulse_start(p_seq, p_ff);
    wait_end(400, cyc, rv, er);
    chk("t2_rv", 32'(rv), 1);
    chk("t2_result", 32'(result), 32'hFFD3);
    chk("t2_wsext", wlog_data[9], 32'hFFFF_FFFF);
    check_seq("t2", 19, p_seq, p_ff);

    // 3a: AWREADY late -> -128*127*9 truncated to 16 bits
    clear_bfm();
    aw_dly = 3; w_dly = 0;
    pulse_start(p_80, p_7f);
    wait_end(600, cyc, rv, er);
    chk("t3a_rv", 32'(rv), 1);
    chk("t3a_result", 32'(result), 32'hC480);
    chk("t3a_viol", viol, 0);
    check_seq("t3a", 19, p_80, p_7f);

    // 3b: WREADY late -> sum of squares 1..9 = 285
    clear_bfm();
    aw_dly = 0; w_dly = 3;
    pulse_start(p_seq, p_seq);
    wait_end(600, cyc, rv, er);
    chk("t3b_rv", 32'(rv), 1);
    chk("t3b_result", 32'(result), 32'h011D);
    chk("t3b_viol", viol, 0);
    check_seq("t3b", 19, p_seq, p_seq);

    // 3c: both ready in the same late cycle -> 9*2*3 = 54
    clear_bfm();
    aw_dly = 2; w_dly = 2;
    pulse_start(p_2, p_3);
    wait_end(600, cyc, rv, er);
    chk("t3c_rv", 32'(rv), 1);
    chk("t3c_result", 32'(result), 32'h0036);
    chk("t3c_viol", viol, 0);
    check_seq("t3c", 19, p_2, p_3);

    // 4: SLVERR on weight 4 (0x38)
    clear_bfm();
    aw_dly = 0; w_dly = 0; err_addr = 7'h38;
    pulse_start(p_4, p_4);
    wait_end(400, cyc, rv, er);
    chk("t4_err", 32'(er), 1);
    chk("t4_no_rv", 32'(rv), 0);
    chk("t4_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t4_err_pulse", 32'(error), 0);
    repeat (5) @(negedge clk);
    chk("t4_awvalid", 32'(M_AXI_AWVALID), 0);
    chk("t4_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("t4_last_addr", 32'(wlog_addr[13]), 32'h38);
    chk("t4_rcount", rcount, 0);
    chk("t4_result", 32'(result), 32'h0036);
    check_seq("t4", 14, p_4, p_4);
    err_addr = 7'h7F;

    // 5: done never set, POLL_MAX=4
    clear_bfm();
    never_done = 1'b1;
    pulse_start(p_ones, p_ones);
    wait_end(400, cyc, rv, er);
    chk("t5_err", 32'(er), 1);
    chk("t5_no_rv", 32'(rv), 0);
    chk("t5_wcount", wcount, 19);
    chk("t5_rcount", rcount, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_rd%0d", i), 32'(rlog_addr[i]), 32'h00);
    chk("t5_result", 32'(result), 32'h0036);
    never_done = 1'b0;

    // 6: reset while AWVALID is waiting, then a clean run ignoring busy starts
    clear_bfm();
    aw_dly = 6;
    pulse_start(p_ones, p_ones);
    cyc = 0;
    while (!M_AXI_AWVALID && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_awvalid_seen", 32'(M_AXI_AWVALID), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_awvalid", 32'(M_AXI_AWVALID), 0);
    chk("t6_rst_wvalid",  32'(M_AXI_WVALID), 0);
    chk("t6_rst_bready",  32'(M_AXI_BREADY), 0);
    chk("t6_rst_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("t6_rst_rready",  32'(M_AXI_RREADY), 0);
    chk("t6_rst_busy",    32'(busy), 0);
    chk("t6_rst_rv",      32'(result_valid), 0);
    chk("t6_rst_error",   32'(error), 0);
    chk("t6_rst_result",  32'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    aw_dly = 0;
    @(negedge clk);
    clear_bfm();
    pulse_start(p_seq, p_seq);
    repeat (10) @(negedge clk);
    pulse_start('0, '0);
    wait_end(400, cyc, rv, er);
    chk("t6_rv", 32'(rv), 1);
    chk("t6_result", 32'(result), 32'h011D);
    chk("t6_viol", viol, 0);
    check_seq("t6", 19, p_seq, p_seq);
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_no_restart", wcount, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
